// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with frame checking and make/break LED tracker
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic        scan_err,
  output logic [10:0] scan_code,
  output logic [3:0]  COUNT,
  output logic        TRIG_ARR,
  output logic [7:0]  CODEWORD,
  output logic [7:0]  LED
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_clk_prev, r_break_pending;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_timeout;
  logic          w_fall, w_valid;
  logic [10:0]   w_frame;
  logic [7:0]    w_data;
  assign w_fall  = r_clk_prev & ~r_clk_sync[1];
  assign w_frame = {r_dat_sync[1], r_shift};
  assign w_data  = w_frame[8:1];
  assign w_valid = ~w_frame[0] & w_frame[10] & ^w_frame[9:1];
  // two-flop synchronisers plus the previous-cycle clock used for edge detection
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
      r_clk_prev <= r_clk_sync[1];
    end
  // deserialiser, frame check, make/break tracker and mid-frame timeout
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      scan_err        <= 1'b0;
      scan_code       <= '0;
      COUNT           <= '0;
      TRIG_ARR        <= 1'b0;
      CODEWORD        <= '0;
      LED             <= '0;
      r_break_pending <= 1'b0;
      r_shift         <= '0;
      r_timeout       <= '0;
    end else begin
      TRIG_ARR <= 1'b0;
      if (w_fall) begin
        r_timeout <= '0;
        if (COUNT == 4'd10) begin
          COUNT     <= '0;
          TRIG_ARR  <= 1'b1;
          scan_code <= w_frame;
          scan_err  <= ~w_valid;
          if (w_valid) begin
            CODEWORD <= w_data;
            if (w_data == 8'hF0)
              r_break_pending <= 1'b1;
            else if (w_data != 8'hE0) begin
              LED             <= r_break_pending ? ((w_data == LED) ? 8'h00 : LED) : w_data;
              r_break_pending <= 1'b0;
            end
          end
        end else begin
          r_shift[COUNT] <= r_dat_sync[1];
          COUNT          <= COUNT + 4'd1;
        end
      end else if (COUNT != 4'd0) begin
        if (r_timeout == TW'(TIMEOUT_CYCLES)) begin
          COUNT     <= '0;
          r_timeout <= '0;
        end else
          r_timeout <= r_timeout + 1'b1;
      end else
        r_timeout <= '0;
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: scoreboard bench driving directed PS/2 frames into ps2_keyboard
module tb_ps2_keyboard;
  localparam int TO = 5000;
  logic        CLK = 1'b0, RST_N, PS2_CLK, PS2_DATA;
  logic        scan_err, TRIG_ARR;
  logic [10:0] scan_code;
  logic [3:0]  COUNT;
  logic [7:0]  CODEWORD, LED;
  typedef struct packed {
    logic [10:0] code;
    logic        err;
    logic [7:0]  cw;
    logic [7:0]  led;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, trig_n = 0;
  logic prev_trig = 1'b0;
  localparam logic [10:0] F75    = 11'b10_0111_0101_0;
  localparam logic [10:0] FAE    = 11'b10_1010_1110_0;
  localparam logic [10:0] FF0    = 11'b11_1111_0000_0;
  localparam logic [10:0] FE0    = 11'b10_1110_0000_0;
  localparam logic [10:0] F16    = 11'b10_0001_0110_0;
  localparam logic [10:0] F75_BP = 11'b11_0111_0101_0;
  localparam logic [10:0] F75_NS = 11'b00_0111_0101_0;

  ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .scan_err(scan_err), .scan_code(scan_code), .COUNT(COUNT),
    .TRIG_ARR(TRIG_ARR), .CODEWORD(CODEWORD), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every TRIG_ARR pulse is matched against the oldest pending expectation
  always @(negedge CLK) begin
    if (TRIG_ARR) begin
      trig_n++;
      chk("trig_single_cycle", {31'd0, prev_trig}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_trig: got pulse expected none at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("scan_code", {21'd0, scan_code}, {21'd0, e.code});
        chk("scan_err", {31'd0, scan_err}, {31'd0, e.err});
        chk("CODEWORD", {24'd0, CODEWORD}, {24'd0, e.cw});
        chk("LED", {24'd0, LED}, {24'd0, e.led});
      end
    end
    prev_trig = TRIG_ARR;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = f[i];
      wait_clk(25);
      PS2_CLK = 1'b0;
      wait_clk(50);
      chk("COUNT_step", {28'd0, COUNT}, (i + 1) % 11);
      PS2_CLK = 1'b1;
      wait_clk(25);
    end
  endtask

  task automatic send_frame(input logic [10:0] f, input logic err, input logic [7:0] cw, input logic [7:0] led);
    q.push_back('{code: f, err: err, cw: cw, led: led});
    send_bits(f, 11);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    wait_clk(5);
    chk("rst_scan_err", {31'd0, scan_err}, 0);
    chk("rst_scan_code", {21'd0, scan_code}, 0);
    chk("rst_COUNT", {28'd0, COUNT}, 0);
    chk("rst_TRIG_ARR", {31'd0, TRIG_ARR}, 0);
    chk("rst_CODEWORD", {24'd0, CODEWORD}, 0);
    chk("rst_LED", {24'd0, LED}, 0);
    RST_N = 1'b1;
    wait_clk(5);
    send_bits(F75, 4);
    chk("mid_frame_COUNT", {28'd0, COUNT}, 4);
    RST_N = 1'b0;
    #1;
    chk("async_rst_COUNT", {28'd0, COUNT}, 0);
    wait_clk(2);
    RST_N = 1'b1;
    wait_clk(10);
    send_frame(F75, 1'b0, 8'h75, 8'h75);
    send_frame(FAE, 1'b0, 8'hAE, 8'hAE);
    send_frame(FF0, 1'b0, 8'hF0, 8'hAE);
    send_frame(F75, 1'b0, 8'h75, 8'hAE);
    wait_clk(5);
    chk("four_frame_pulses", trig_n, 4);
    send_frame(F75, 1'b0, 8'h75, 8'h75);
    send_frame(FF0, 1'b0, 8'hF0, 8'h75);
    send_frame(F75, 1'b0, 8'h75, 8'h00);
    send_frame(FAE, 1'b0, 8'hAE, 8'hAE);
    send_frame(F75_BP, 1'b1, 8'hAE, 8'hAE);
    send_frame(F75_NS, 1'b1, 8'hAE, 8'hAE);
    send_frame(F75, 1'b0, 8'h75, 8'h75);
    send_frame(FE0, 1'b0, 8'hE0, 8'h75);
    send_frame(F16, 1'b0, 8'h16, 8'h16);
    send_bits(F75, 5);
    wait_clk(TO + 10);
    chk("timeout_COUNT", {28'd0, COUNT}, 0);
    chk("timeout_no_trig", trig_n, 13);
    chk("timeout_scan_code", {21'd0, scan_code}, {21'd0, F16});
    chk("timeout_LED", {24'd0, LED}, 8'h16);
    send_frame(F75, 1'b0, 8'h75, 8'h75);
    wait_clk(20);
    chk("total_pulses", trig_n, 14);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
